cordic_ci_initiator: RTL

- Master-side sequencer for the multicycle cosine CORDIC custom-instruction slave.
- Accepts FP32 angles on a valid/ready stream.
- Per angle, drives the slave's start/clk_en/dataa handshake, waits for done, captures the result, and presents it on a one-entry valid/ready output stream.
- Sits between a host/DMA feeder and the CORDIC slave, for batch cosine evaluation without CPU polling.

---
 rtl/cordic_ci_initiator.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/cordic_ci_initiator.sv
// Master-side sequencer for the multicycle cosine CORDIC custom-instruction
// slave. Takes FP32 angles from a valid/ready stream, runs one slave
// operation per angle, and presents the cosine (or a NaN timeout marker) on
// a one-entry valid/ready output register.
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | no op in flight; accepts an angle when the output slot is free
// ISSUE | one cycle of start/clk_en to load the slave; done is stale here
// WAIT  | slave iterating; capture on done, abort after TIMEOUT_CYCLES
module cordic_ci_initiator #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 16
) (
    input  logic             clock,
    input  logic             aclr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_err,
    output logic             ci_clk_en,
    output logic             ci_start,
    output logic [31:0]      ci_dataa,
    input  logic [31:0]      ci_result,
    input  logic             ci_done,
    output logic [CNT_W-1:0] op_count,
    output logic [CNT_W-1:0] timeout_count
);

    localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_NAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              accept;
    logic              capture_ok;
    logic              capture_to;

    // Next-state decode and slave handshake; everything is forced quiet while
    // aclr is high so the slave never sees a start or enable during reset.
    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        ci_start   = 1'b0;
        ci_clk_en  = 1'b0;
        accept     = 1'b0;
        capture_ok = 1'b0;
        capture_to = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = !out_valid || out_ready;
                if (in_valid && in_ready) begin
                    accept    = 1'b1;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                ci_start  = 1'b1;
                ci_clk_en = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (ci_done) begin
                    capture_ok = 1'b1;
                    state_nxt  = S_IDLE;
                end else if (wait_cnt == '0) begin
                    capture_to = 1'b1;
                    state_nxt  = S_IDLE;
                end else begin
                    // Enable only while done is low so the slave freezes
                    // with done/result stable on the capture cycle.
                    ci_clk_en = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (aclr) begin
            in_ready   = 1'b0;
            ci_start   = 1'b0;
            ci_clk_en  = 1'b0;
            accept     = 1'b0;
            capture_ok = 1'b0;
            capture_to = 1'b0;
            state_nxt  = S_IDLE;
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (aclr) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Angle register and timeout down-counter (terminal count at zero).
    always_ff @(posedge clock) begin
        if (aclr) begin
            ci_dataa <= '0;
            wait_cnt <= '0;
        end else begin
            if (accept) ci_dataa <= in_data;
            if (state == S_ISSUE)
                wait_cnt <= WAIT_LOAD;
            else if (state == S_WAIT && wait_cnt != '0)
                wait_cnt <= wait_cnt - WAIT_W'(1);
        end
    end

    // Output slot and statistics; a capture wins over a same-cycle consume.
    always_ff @(posedge clock) begin
        if (aclr) begin
            out_valid     <= 1'b0;
            out_err       <= 1'b0;
            out_data      <= '0;
            op_count      <= '0;
            timeout_count <= '0;
        end else if (capture_ok) begin
            out_valid <= 1'b1;
            out_err   <= 1'b0;
            out_data  <= ci_result;
            op_count  <= op_count + CNT_W'(1);
        end else if (capture_to) begin
            out_valid <= 1'b1;
            out_err   <= 1'b1;
            out_data  <= TIMEOUT_NAN;
            if (timeout_count != '1)
                timeout_count <= timeout_count + CNT_W'(1);
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
